// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit common-anode seven-segment driver: hex/BCD decode,
// per-digit blank and dp, leading-zero suppression, per-frame input snapshot, anode guard.
module seven_seg_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_COUNT    = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || DIV_COUNT < 2 || GUARD_CYCLES < 1 ||
      GUARD_CYCLES > DIV_COUNT - 1) begin : g_bad_cfg
    $error("seven_seg_mux: illegal NUM_DIGITS/DIV_COUNT/GUARD_CYCLES");
  end

  function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b100_0000;
      4'h1: s = 7'b111_1001;
      4'h2: s = 7'b010_0100;
      4'h3: s = 7'b011_0000;
      4'h4: s = 7'b001_1001;
      4'h5: s = 7'b001_0010;
      4'h6: s = 7'b000_0010;
      4'h7: s = 7'b111_1000;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b001_0000;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b000_0011;
      4'hC: s = 7'b100_0110;
      4'hD: s = 7'b010_0001;
      4'hE: s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    // BCD mode shows nothing for 10-15 rather than a misleading letter
    if (!hex && v > 4'h9) s = 7'b111_1111;
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_sh_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic                    hex_sh_q, lz_sh_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q;
  logic                    snap;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;

  assign snap = (cnt_q == '0) && (idx_q == '0);

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // A digit is a leading zero when it and every more-significant nibble is zero
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (data_sh_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    sel       = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel[k]    = 1'b1;
        cur_nib   = data_sh_q[4*k +: 4];
        cur_dp    = dp_sh_q[k];
        cur_blank = blank_sh_q[k] | (lz_sh_q & lz_mask[k]);
      end
    end
  end

  always_comb begin
    an_d   = '1;
    seg_d  = 7'b111_1111;
    dp_n_d = 1'b1;
    if (cnt_q >= CNT_GUARD) begin
      an_d   = ~sel;
      dp_n_d = ~cur_dp;
      seg_d  = cur_blank ? 7'b111_1111 : decode(cur_nib, hex_sh_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '1;
      hex_sh_q   <= 1'b0;
      lz_sh_q    <= 1'b0;
      seg_q      <= 7'b111_1111;
      dp_n_q     <= 1'b1;
      an_q       <= '1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      an_q   <= an_d;
      tick_q <= snap;
      if (snap) begin
        data_sh_q  <= data;
        dp_sh_q    <= dp;
        blank_sh_q <= blank;
        hex_sh_q   <= hex_mode;
        lz_sh_q    <= lz_blank;
      end
    end
  end

  assign segments   = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux at NUM_DIGITS=4, DIV_COUNT=4, GUARD_CYCLES=1.
module tb_seven_seg_mux;

  localparam logic [6:0] S0 = 7'b100_0000, S1 = 7'b111_1001, S2 = 7'b010_0100,
                         S3 = 7'b011_0000, S5 = 7'b001_0010, SA = 7'b000_1000,
                         SD = 7'b010_0001, SE = 7'b000_0110, SF = 7'b000_1110,
                         SB = 7'b111_1111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp, blank;
  logic        hex_mode, lz_blank;
  logic [6:0]  segments;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_tick;

  exp_t q[$];
  int   nvec = 0;
  int   errs = 0;

  seven_seg_mux #(.NUM_DIGITS(4), .DIV_COUNT(4), .GUARD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank),
    .hex_mode(hex_mode), .lz_blank(lz_blank), .segments(segments),
    .dp_n(dp_n), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    exp_t o;
    o.an = an; o.seg = segments; o.dpn = dp_n; o.tick = frame_tick;
    return o;
  endfunction

  task automatic compare(input string name, input exp_t got, input exp_t want);
    nvec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s t=%0t: got an=%b seg=%b dp_n=%b tick=%b, want an=%b seg=%b dp_n=%b tick=%b",
               name, $time, got.an, got.seg, got.dpn, got.tick,
               want.an, want.seg, want.dpn, want.tick);
    end
  endtask

  // Monitor: every edge with a queued expectation is checked 1 ns later
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) compare("scan", observed(), q.pop_front());
  end

  // Expectation for the edge leaving frame position p (cnt = p%4, idx = p/4)
  task automatic edge_exp(input int p, input logic [3:0][6:0] segs, input logic [3:0] dpn);
    exp_t e;
    int c, k;
    c = p % 4;
    k = p / 4;
    e.tick = (p == 0);
    e.an   = 4'hF;
    e.seg  = SB;
    e.dpn  = 1'b1;
    if (c != 0) begin
      e.an[k] = 1'b0;
      e.seg   = segs[k];
      e.dpn   = dpn[k];
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [3:0][6:0] segs, input logic [3:0] dpn,
                           input int chg_p, input logic [15:0] chg_data);
    for (int p = 0; p < 16; p++) begin
      if (p == chg_p) data = chg_data;
      edge_exp(p, segs, dpn);
    end
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] bl,
                        input logic hx, input logic lz);
    data = d; dp = dpi; blank = bl; hex_mode = hx; lz_blank = lz;
  endtask

  localparam exp_t RST_EXP = '{an: 4'hF, seg: 7'h7F, dpn: 1'b1, tick: 1'b0};

  initial begin
    rst = 1'b1;
    set_in(16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1 compare("reset_initial", observed(), RST_EXP);

    // Scan order, two frames
    set_in(16'h3210, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    run_frame({S3, S2, S1, S0}, 4'hF, -1, 16'h0);
    run_frame({S3, S2, S1, S0}, 4'hF, -1, 16'h0);

    // Hex vs BCD
    set_in(16'hFEDA, 4'h0, 4'h0, 1'b1, 1'b0);
    run_frame({SF, SE, SD, SA}, 4'hF, -1, 16'h0);
    hex_mode = 1'b0;
    run_frame({SB, SB, SB, SB}, 4'hF, -1, 16'h0);

    // Leading-zero suppression
    set_in(16'h0050, 4'b1000, 4'h0, 1'b0, 1'b1);
    run_frame({SB, SB, S5, S0}, 4'b0111, -1, 16'h0);
    set_in(16'h0000, 4'h0, 4'h0, 1'b0, 1'b1);
    run_frame({SB, SB, SB, S0}, 4'hF, -1, 16'h0);

    // Blank mask with dp surviving
    set_in(16'h3210, 4'b0100, 4'b0101, 1'b0, 1'b0);
    run_frame({S3, SB, S1, SB}, 4'b1011, -1, 16'h0);

    // Snapshot coherence: change mid-frame while idx = 2
    set_in(16'h1111, 4'h0, 4'h0, 1'b0, 1'b0);
    run_frame({S1, S1, S1, S1}, 4'hF, 9, 16'h2222);
    run_frame({S2, S2, S2, S2}, 4'hF, -1, 16'h0);

    // Reset mid-slot, then fresh scan from digit 0
    set_in(16'h3210, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) edge_exp(p, {S3, S2, S1, S0}, 4'hF);
    #1 rst = 1'b1;
    #1 compare("reset_async", observed(), RST_EXP);
    @(posedge clk);
    #2 compare("reset_held", observed(), RST_EXP);
    @(negedge clk);
    rst = 1'b0;
    run_frame({S3, S2, S1, S0}, 4'hF, -1, 16'h0);

    nvec++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
